// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus sequencer.
//   cyc_type_e : machine-cycle kinds requested by the core
//   tstate_e   : T-state encoding, also driven on T_State
//   bus_ctl_t  : registered strobe bundle (active-low strobes plus D_Oe)
//   bus_ctl()  : strobe pattern for a given T-state / cycle kind
package z80_bus_pkg;

  typedef enum logic [1:0] {
    CYC_FETCH = 2'b00,
    CYC_MEM   = 2'b01,
    CYC_IO    = 2'b10,
    CYC_RSVD  = 2'b11
  } cyc_type_e;

  typedef enum logic [2:0] {
    TS_IDLE = 3'd0,
    TS_T1   = 3'd1,
    TS_T2   = 3'd2,
    TS_TW   = 3'd3,
    TS_T3   = 3'd4,
    TS_T4   = 3'd5
  } tstate_e;

  localparam int IO_WAITS_MAX = 3;
  localparam int WAIT_CNT_W   = 2;

  typedef struct packed {
    logic m1_n;
    logic mreq_n;
    logic iorq_n;
    logic rd_n;
    logic wr_n;
    logic rfsh_n;
    logic d_oe;
  } bus_ctl_t;

  localparam bus_ctl_t BUS_IDLE = bus_ctl_t'(7'b111111_0);

  // Strobes that should be visible while the bus sits in state st.
  // T3/T4 of a fetch only carry refresh strobes when rfsh_en is set.
  function automatic bus_ctl_t bus_ctl(input tstate_e st, input cyc_type_e ty,
                                       input logic wr, input logic rfsh_en);
    bus_ctl_t c;
    c = BUS_IDLE;
    case (ty)
      CYC_FETCH: begin
        if (st inside {TS_T1, TS_T2, TS_TW}) begin
          c.m1_n   = 1'b0;
          c.mreq_n = 1'b0;
          c.rd_n   = 1'b0;
        end else if (rfsh_en && st == TS_T3) begin
          c.mreq_n = 1'b0;
          c.rfsh_n = 1'b0;
        end else if (rfsh_en && st == TS_T4) begin
          c.rfsh_n = 1'b0;
        end
      end
      CYC_MEM: begin
        if (st inside {TS_T1, TS_T2, TS_TW, TS_T3}) begin
          c.mreq_n = 1'b0;
          if (wr) begin
            c.d_oe = 1'b1;
            if (st != TS_T1) c.wr_n = 1'b0;
          end else begin
            c.rd_n = 1'b0;
          end
        end
      end
      CYC_IO: begin
        if (st inside {TS_T1, TS_T2, TS_TW, TS_T3}) begin
          if (wr) c.d_oe = 1'b1;
          if (st != TS_T1) begin
            c.iorq_n = 1'b0;
            if (wr) c.wr_n = 1'b0;
            else    c.rd_n = 1'b0;
          end
        end
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/z80_refresh_ctr.sv
// 7-bit DRAM refresh counter (R register).
// Advances by one per completed opcode fetch, wrapping 7'h7F -> 0.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset, clears R
//   inc  in   one-cycle increment strobe
//   r    out  current refresh count
module z80_refresh_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [6:0] r
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r <= 7'd0;
    else if (inc) r <= r + 7'd1;
  end

endmodule

// File: rtl/z80_bus_sequencer.sv
// Z80 machine-cycle sequencer: runs FETCH / MEM / IO cycles as T-states
// paced by Clk_En, inserting automatic (IO) and external (Wait_n) waits.
// Optional feature macro: Z80_REFRESH_EN (R counter + refresh strobes in
// fetch T3/T4). Without it RFSH_n stays high and A holds the fetch address.
// Ports:
//   Clk, Reset            clock, async active-high reset
//   Clk_En                T-state tick; nothing advances while low
//   Cyc_Req/Type/Wr       cycle request, held until Cyc_Ack
//   Addr, Dout            cycle address and write data
//   I_Reg                 upper byte of refresh address
//   Wait_n, Din           external wait and read data
//   Cyc_Ack, Cyc_Done     tick-cycle pulses: accepted / finished
//   Rd_Data               last captured read or opcode byte
//   A, D_Out, D_Oe        bus address, write data, data drive enable
//   M1_n..RFSH_n          active-low bus strobes
//   T_State               current T-state encoding
//
// state | meaning
// IDLE  | no cycle in progress, waiting for Cyc_Req
// T1    | address phase, A/D_Out just loaded
// T2    | strobe phase; wait sampled here when no auto waits
// TW    | wait state: auto IO waits count down, then Wait_n held low extends
// T3    | data phase (read capture / refresh start for fetch)
// T4    | fetch only, refresh tail
module z80_bus_sequencer
  import z80_bus_pkg::*;
#(
  parameter int IO_WAITS = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Clk_En,
  input  logic        Cyc_Req,
  input  logic [1:0]  Cyc_Type,
  input  logic        Cyc_Wr,
  input  logic [15:0] Addr,
  input  logic [7:0]  Dout,
  input  logic [7:0]  I_Reg,
  input  logic        Wait_n,
  input  logic [7:0]  Din,
  output logic        Cyc_Ack,
  output logic        Cyc_Done,
  output logic [7:0]  Rd_Data,
  output logic [15:0] A,
  output logic [7:0]  D_Out,
  output logic        D_Oe,
  output logic        M1_n,
  output logic        MREQ_n,
  output logic        IORQ_n,
  output logic        RD_n,
  output logic        WR_n,
  output logic        RFSH_n,
  output logic [2:0]  T_State
);

  localparam int IO_WAITS_C = (IO_WAITS > IO_WAITS_MAX) ? IO_WAITS_MAX : IO_WAITS;
  // The first auto TW is entered from T2, so the counter starts one short.
  localparam logic [WAIT_CNT_W-1:0] IO_WAIT_LOAD =
    (IO_WAITS_C > 0) ? WAIT_CNT_W'(IO_WAITS_C - 1) : '0;

  tstate_e                 state_q, state_d;
  cyc_type_e               type_q, type_d;
  logic                    wr_q, wr_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [15:0]             a_q, a_d;
  logic [7:0]              d_out_q, d_out_d;
  logic [7:0]              rd_q, rd_d;
  bus_ctl_t                ctl_q, ctl_d;
  logic                    accept, last, entering_t3;
  logic [15:0]             rfsh_addr;

`ifdef Z80_REFRESH_EN
  localparam logic RFSH_EN = 1'b1;
  logic [6:0] r_cnt;

  z80_refresh_ctr u_refresh (
    .clk (Clk),
    .rst (Reset),
    .inc (Clk_En && (state_q == TS_T4)),
    .r   (r_cnt)
  );

  assign rfsh_addr = {I_Reg, 1'b0, r_cnt};
`else
  localparam logic RFSH_EN = 1'b0;
  assign rfsh_addr = {I_Reg, 8'h00};
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= TS_IDLE;
      type_q     <= CYC_FETCH;
      wr_q       <= 1'b0;
      wait_cnt_q <= '0;
      a_q        <= '0;
      d_out_q    <= '0;
      rd_q       <= '0;
      ctl_q      <= BUS_IDLE;
    end else if (Clk_En) begin
      state_q    <= state_d;
      type_q     <= type_d;
      wr_q       <= wr_d;
      wait_cnt_q <= wait_cnt_d;
      a_q        <= a_d;
      d_out_q    <= d_out_d;
      rd_q       <= rd_d;
      ctl_q      <= ctl_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    wr_d        = wr_q;
    wait_cnt_d  = wait_cnt_q;
    a_d         = a_q;
    d_out_d     = d_out_q;
    rd_d        = rd_q;
    accept      = 1'b0;
    last        = 1'b0;
    entering_t3 = 1'b0;

    if (Clk_En) begin
      case (state_q)
        TS_IDLE: ;
        TS_T1:   state_d = TS_T2;
        TS_T2: begin
          if (type_q == CYC_RSVD) begin
            state_d = TS_T3;
          end else if (type_q == CYC_IO && IO_WAITS_C > 0) begin
            state_d    = TS_TW;
            wait_cnt_d = IO_WAIT_LOAD;
          end else if (!Wait_n) begin
            state_d    = TS_TW;
            wait_cnt_d = '0;
          end else begin
            state_d = TS_T3;
          end
        end
        TS_TW: begin
          // Auto waits ignore Wait_n; only the final one samples it.
          if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - 1'b1;
          else if (Wait_n)      state_d    = TS_T3;
        end
        TS_T3: begin
          if (type_q == CYC_FETCH) state_d = TS_T4;
          else                     last    = 1'b1;
        end
        TS_T4:   last = 1'b1;
        default: state_d = TS_IDLE;
      endcase

      if (last) state_d = TS_IDLE;

      entering_t3 = (state_q inside {TS_T2, TS_TW}) && (state_d == TS_T3);

      if (entering_t3 && type_q == CYC_FETCH) begin
        rd_d = Din;
        if (RFSH_EN) a_d = rfsh_addr;
      end

      if (last && (type_q inside {CYC_MEM, CYC_IO}) && !wr_q) rd_d = Din;

      // Acceptance on the closing tick gives back-to-back cycles.
      if ((state_q == TS_IDLE || last) && Cyc_Req) begin
        accept  = 1'b1;
        state_d = TS_T1;
        type_d  = cyc_type_e'(Cyc_Type);
        wr_d    = Cyc_Wr && (cyc_type_e'(Cyc_Type) != CYC_FETCH);
        a_d     = Addr;
        d_out_d = Dout;
      end
    end

    ctl_d = bus_ctl(state_d, type_d, wr_d, RFSH_EN);
  end

  assign Cyc_Ack  = accept && !Reset;
  assign Cyc_Done = last;
  assign Rd_Data  = rd_q;
  assign A        = a_q;
  assign D_Out    = d_out_q;
  assign D_Oe     = ctl_q.d_oe;
  assign M1_n     = ctl_q.m1_n;
  assign MREQ_n   = ctl_q.mreq_n;
  assign IORQ_n   = ctl_q.iorq_n;
  assign RD_n     = ctl_q.rd_n;
  assign WR_n     = ctl_q.wr_n;
  assign RFSH_n   = ctl_q.rfsh_n;
  assign T_State  = state_q;

endmodule
